clk_div_multi: RTL and testbench

- Multi-channel, runtime-programmable clock divider and tick generator. It replaces the fixed single-rate dividers, such as the 5 Hz joystick and snake-step dividers.
- Each channel produces two outputs: a one-cycle enable pulse (TICK) and a 50%-duty toggle output (CLKOUT), both at a programmable rate.
- Divisor updates are glitch-free: a new divisor is taken at the channel's next terminal count.
- All channels share CLK and can be realigned with a single SYNC pulse.

---
 rtl/clk_div_multi.sv | 60 ++++++
 tb/tb_clk_div_multi.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable tick / 50%-duty clock divider with shadowed divisor updates.
module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 10000000,
  parameter int CH_IDX_W    = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_CH-1:0]   CH_EN,
  input  logic                SYNC,
  input  logic                CFG_WE,
  input  logic [CH_IDX_W-1:0] CFG_CH,
  input  logic [CNT_W-1:0]    CFG_DIV,
  output logic                CFG_ERR,
  output logic [NUM_CH-1:0]   CFG_PEND,
  output logic [NUM_CH-1:0]   TICK,
  output logic [NUM_CH-1:0]   CLKOUT
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
  logic cfg_ok;
  assign cfg_ok = (CFG_DIV != '0) && (32'(CFG_CH) < NUM_CH);
  always_ff @(posedge CLK)
    CFG_ERR <= RESET ? 1'b0 : CFG_WE && !cfg_ok;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt, act, shd, nxt;
    logic wr, tc, tick_r, clk_r, pend_r;
    assign wr  = CFG_WE && cfg_ok && (CFG_CH == CH_IDX_W'(g));
    assign nxt = wr ? CFG_DIV : shd;
    assign tc  = cnt == act - CNT_W'(1);
    // shd equals act whenever nothing is pending, so reloading act from nxt on every
    // restart covers write-through, pending apply and the no-change case alike
    always_ff @(posedge CLK) begin
      if (RESET) begin
        cnt    <= '0;
        act    <= DEF;
        shd    <= DEF;
        tick_r <= 1'b0;
        clk_r  <= 1'b0;
        pend_r <= 1'b0;
      end else begin
        shd <= nxt;
        if (!CH_EN[g] || SYNC || tc) begin
          cnt    <= '0;
          act    <= nxt;
          pend_r <= 1'b0;
          tick_r <= CH_EN[g] && !SYNC;
          clk_r  <= CH_EN[g] && !SYNC && !clk_r;
        end else begin
          cnt    <= cnt + CNT_W'(1);
          tick_r <= 1'b0;
          pend_r <= pend_r || wr;
        end
      end
    end
    assign TICK[g]     = tick_r;
    assign CLKOUT[g]   = clk_r;
    assign CFG_PEND[g] = pend_r;
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed and randomized checks of clk_div_multi against an event-time reference model.
module tb_clk_div_multi;
  localparam int N = 4, W = 27, DEF = 10, IW = 3;
  logic CLK = 1'b0, RESET = 1'b1, SYNC = 1'b0, CFG_WE = 1'b0;
  logic [N-1:0] CH_EN = '0;
  logic [IW-1:0] CFG_CH = '0;
  logic [W-1:0] CFG_DIV = '0;
  logic CFG_ERR;
  logic [N-1:0] CFG_PEND, TICK, CLKOUT;

  clk_div_multi #(.NUM_CH(N), .CNT_W(W), .DEFAULT_DIV(DEF), .CH_IDX_W(IW)) dut (
    .CLK(CLK), .RESET(RESET), .CH_EN(CH_EN), .SYNC(SYNC), .CFG_WE(CFG_WE),
    .CFG_CH(CFG_CH), .CFG_DIV(CFG_DIV), .CFG_ERR(CFG_ERR), .CFG_PEND(CFG_PEND),
    .TICK(TICK), .CLKOUT(CLKOUT));

  always #5 CLK = ~CLK;

  int compared = 0, mismatched = 0, t = 0, t0 = 0;
  // model: each channel knows its period and the absolute edge number of its next tick
  int m_per[N], m_pval[N], m_next[N];
  logic [N-1:0] m_tick, m_clk, m_pend;
  logic m_err;

  task automatic cycle();
    logic ok;
    ok = (CFG_DIV != '0) && (int'(CFG_CH) < N);
    t++;
    m_err = !RESET && CFG_WE && !ok;
    for (int i = 0; i < N; i++) begin
      logic wr;
      wr = CFG_WE && ok && (int'(CFG_CH) == i);
      if (RESET) begin
        m_per[i] = DEF; m_pend[i] = 1'b0; m_tick[i] = 1'b0; m_clk[i] = 1'b0;
        m_next[i] = t + DEF;
      end else if (!CH_EN[i] || SYNC || t == m_next[i]) begin
        if (wr) m_per[i] = int'(CFG_DIV);
        else if (m_pend[i]) m_per[i] = m_pval[i];
        m_pend[i] = 1'b0;
        m_tick[i] = CH_EN[i] && !SYNC;
        m_clk[i]  = CH_EN[i] && !SYNC && !m_clk[i];
        m_next[i] = t + m_per[i];
      end else begin
        m_tick[i] = 1'b0;
        if (wr) begin m_pend[i] = 1'b1; m_pval[i] = int'(CFG_DIV); end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; CH_EN = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      cycle();
      compared++;
      if ({TICK, CLKOUT, CFG_PEND, CFG_ERR} !== '0) begin
        mismatched++;
        $display("FAIL reset t=%0d tick=%b clkout=%b pend=%b err=%b required all 0", t, TICK, CLKOUT, CFG_PEND, CFG_ERR);
      end
    end
    t0 = t;
    RESET = 1'b0;
  endtask

  task automatic test_basic();
    logic e_tick, e_clk, e_pend;
    for (int c = 1; c <= 35; c++) begin
      CFG_WE = (c == 13); CFG_CH = 3'd0; CFG_DIV = W'(4);
      cycle();
      e_tick = (c == 10 || c == 20 || c == 24 || c == 28 || c == 32);
      e_clk  = (c >= 10 && c < 20) || (c >= 24 && c < 28) || c >= 32;
      e_pend = (c >= 13 && c < 20);
      compared++;
      if ({TICK, CLKOUT, CFG_PEND, CFG_ERR} !== {3'b000, e_tick, 3'b000, e_clk, 3'b000, e_pend, 1'b0}) begin
        mismatched++;
        $display("FAIL basic cycle=%0d tick=%b clkout=%b pend=%b err=%b required tick0=%b clk0=%b pend0=%b", c, TICK, CLKOUT, CFG_PEND, CFG_ERR, e_tick, e_clk, e_pend);
      end
    end
    CFG_WE = 1'b0;
  endtask

  task automatic test_write_through();
    int tw = -1;
    CH_EN = 4'b0011;
    for (int k = 0; k < 40; k++) begin
      CFG_WE = (tw < 0) && (m_next[1] == t + 1); CFG_CH = 3'd1; CFG_DIV = W'(3);
      if (CFG_WE) tw = t + 1;
      cycle();
      compared++;
      if ({TICK, CLKOUT, CFG_PEND, CFG_ERR} !== {m_tick, m_clk, m_pend, m_err}) begin
        mismatched++;
        $display("FAIL write_through t=%0d tick=%b/%b clkout=%b/%b pend=%b/%b err=%b/%b", t, TICK, m_tick, CLKOUT, m_clk, CFG_PEND, m_pend, CFG_ERR, m_err);
      end
      if (tw >= 0 && t <= tw + 7) begin
        compared++;
        if (TICK[1] !== (t == tw || t == tw + 3 || t == tw + 6) || CFG_PEND[1] !== 1'b0) begin
          mismatched++;
          $display("FAIL write_through_ch1 t=%0d tick1=%b pend1=%b required tick1=%b pend1=0", t, TICK[1], CFG_PEND[1], (t == tw || t == tw + 3 || t == tw + 6));
        end
      end
    end
    CFG_WE = 1'b0;
    compared++;
    if (tw < 0) begin
      mismatched++;
      $display("FAIL write_through_timeout no terminal count of ch1 seen within 40 cycles");
    end
  endtask

  task automatic test_cfg_err();
    logic [IW-1:0] chs [4] = '{3'd2, 3'd0, 3'd5, 3'd0};
    logic [W-1:0]  dvs [4] = '{27'd0, 27'd0, 27'd7, 27'd0};
    logic          wes [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    CH_EN = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      CFG_WE = wes[k]; CFG_CH = chs[k]; CFG_DIV = dvs[k];
      cycle();
      compared++;
      if (CFG_ERR !== wes[k] || CFG_PEND[2] !== 1'b0 || {TICK, CLKOUT, CFG_PEND} !== {m_tick, m_clk, m_pend}) begin
        mismatched++;
        $display("FAIL cfg_err step=%0d err=%b pend=%b tick=%b required err=%b pend=%b tick=%b", k, CFG_ERR, CFG_PEND, TICK, wes[k], m_pend, m_tick);
      end
    end
  endtask

  task automatic test_sync();
    int ts = -1;
    RESET = 1'b1; CH_EN = 4'b1111; cycle(); RESET = 1'b0;
    for (int k = 0; k < 40; k++) begin
      SYNC = (ts < 0) && (k > 12) && (m_next[0] == t + 1);
      if (SYNC) ts = t + 1;
      cycle();
      compared++;
      if ({TICK, CLKOUT, CFG_PEND, CFG_ERR} !== {m_tick, m_clk, m_pend, m_err}) begin
        mismatched++;
        $display("FAIL sync t=%0d tick=%b/%b clkout=%b/%b pend=%b/%b err=%b/%b", t, TICK, m_tick, CLKOUT, m_clk, CFG_PEND, m_pend, CFG_ERR, m_err);
      end
      if (ts >= 0 && t <= ts + 10) begin
        compared++;
        if (TICK !== ((t == ts + 10) ? 4'hF : 4'h0) || (t == ts && CLKOUT !== 4'h0)) begin
          mismatched++;
          $display("FAIL sync_align t=%0d tick=%b clkout=%b required tick=%b", t, TICK, CLKOUT, (t == ts + 10) ? 4'hF : 4'h0);
        end
      end
    end
    SYNC = 1'b0;
    compared++;
    if (ts < 0) begin
      mismatched++;
      $display("FAIL sync_timeout no terminal count of ch0 seen within 40 cycles");
    end
  endtask

  task automatic test_reset_mid();
    CH_EN = 4'b0001;
    while (m_next[0] <= t + 2) cycle();
    CFG_WE = 1'b1; CFG_CH = 3'd0; CFG_DIV = W'(6);
    cycle();
    CFG_WE = 1'b0;
    compared++;
    if (CFG_PEND !== 4'b0001) begin
      mismatched++;
      $display("FAIL reset_mid_pend pend=%b required 0001", CFG_PEND);
    end
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    t0 = t;
    compared++;
    if ({TICK, CLKOUT, CFG_PEND, CFG_ERR} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid t=%0d tick=%b clkout=%b pend=%b err=%b required all 0", t, TICK, CLKOUT, CFG_PEND, CFG_ERR);
    end
    for (int c = 1; c <= 21; c++) begin
      cycle();
      compared++;
      if (TICK[0] !== (c == 10 || c == 20) || CFG_PEND !== 4'b0000) begin
        mismatched++;
        $display("FAIL reset_mid_ticks cycle=%0d tick0=%b pend=%b required tick0=%b pend=0000", c, TICK[0], CFG_PEND, (c == 10 || c == 20));
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      RESET  = ($urandom_range(0, 299) == 0);
      SYNC   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 39) == 0) CH_EN[$urandom_range(0, N - 1)] ^= 1'b1;
      CFG_WE  = ($urandom_range(0, 5) == 0);
      CFG_CH  = IW'($urandom_range(0, 5));
      CFG_DIV = W'($urandom_range(0, 8));
      cycle();
      compared++;
      if ({TICK, CLKOUT, CFG_PEND, CFG_ERR} !== {m_tick, m_clk, m_pend, m_err}) begin
        mismatched++;
        $display("FAIL random t=%0d tick=%b/%b clkout=%b/%b pend=%b/%b err=%b/%b", t, TICK, m_tick, CLKOUT, m_clk, CFG_PEND, m_pend, CFG_ERR, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_write_through();
    test_cfg_err();
    test_sync();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
